dram_req_sequencer: RTL
=======================

Name: dram_req_sequencer

Overview:
- Sits directly upstream of the DDR2 DRAM controller and converts a 288-bit, single-cycle user request port into the controller's two-beat application protocol.
- Writes: one command cycle carrying beat 0, then beat 1 on the following cycle.
- Reads: limits outstanding reads with a credit counter and reassembles the two 144-bit return beats into one 288-bit response.
- Gates all traffic on phy_rdy.

Parameters:
ADDR_WIDTH, 32, controller command address width
BEAT_WIDTH, 144, data width of one controller beat
BE_WIDTH, 18, byte enables per beat (BEAT_WIDTH/8)
MAX_RD_OUT, 8, maximum outstanding read commands (1..15)
CNT_WIDTH, 4, width of outstanding-read counter; must hold MAX_RD_OUT

Ports:
clk0  in  1  sole clock, rising edge
rst0_n  in  1  asynchronous active-low reset
phy_rdy  in  1  controller calibration complete
usr_req_valid  in  1  user request present
usr_req_ready  out  1  request accepted when valid&&ready
usr_req_rnw  in  1  1=read, 0=write
usr_req_addr  in  ADDR_WIDTH  request address, passed through unmodified
usr_wr_data  in  2*BEAT_WIDTH  write data; [143:0]=beat 0, [287:144]=beat 1
usr_wr_be  in  2*BE_WIDTH  byte enables, active high; [17:0]=beat 0
usr_rd_valid  out  1  one-cycle pulse, read response complete
usr_rd_data  out  2*BEAT_WIDTH  read response; first returned beat in low half
rd_outstanding  out  CNT_WIDTH  read commands issued but not fully returned
err_unexp_rd  out  1  sticky; read beat arrived with no read outstanding
app_cmd_addr  out  ADDR_WIDTH  to controller
app_cmd_rnw  out  1  to controller
app_cmd_valid  out  1  to controller
app_wr_data  out  BEAT_WIDTH  to controller
app_wr_be  out  BE_WIDTH  to controller, active high
app_rd_data  in  BEAT_WIDTH  from controller
app_rd_valid  in  1  from controller

Behaviour:
Reset:
- rst0_n low (asynchronous): all app_* outputs, usr_rd_valid, usr_rd_data, rd_outstanding, err_unexp_rd, beat-phase flag = 0; state = IDLE.
- Release is used synchronously.

Output timing:
- All app_* outputs are registered. Accept at cycle A → app_cmd_valid=1 at A+1.

State machine:
- IDLE: usr_req_ready=0. Go to RUN when phy_rdy=1.
- RUN: usr_req_ready = phy_rdy && (rnw || 1) && !(usr_req_rnw && rd_outstanding==MAX_RD_OUT).
  - Ready is combinational from state, phy_rdy, counter and usr_req_rnw.
  - Read accept: next cycle app_cmd_valid=1, rnw=1, addr latched; rd_outstanding+1; stay RUN. Back-to-back reads are allowed every cycle.
  - Write accept: next cycle app_cmd_valid=1, rnw=0, app_wr_data/app_wr_be = beat 0; beat 1 and its byte enables are latched internally; go to WR_B1.
  - phy_rdy=0 with no accept → IDLE.
- WR_B1 (the cycle the write command is on the app bus): usr_req_ready=0. Next cycle app_cmd_valid=0, app_wr_data/app_wr_be = beat 1. Return to RUN, or IDLE if phy_rdy=0.
  - Effect: write accepts are at least 2 cycles apart, and no command ever occupies the cycle after a write command.

Idle bus values:
- When app_cmd_valid=0 and no beat 1 is being driven, app_wr_data, app_wr_be and app_cmd_addr hold their last values; app_cmd_rnw holds.

Read return:
- Phase flag toggles on each app_rd_valid.
- Phase 0: beat stored to the low half.
- Phase 1: beat stored to the high half; usr_rd_valid=1 and the full usr_rd_data appear in the next cycle; rd_outstanding-1.
- usr_rd_data holds until the next completion. There is no user back-pressure.

Counter and error rules:
- Increment and decrement in the same cycle: counter unchanged.
- Counter never wraps; ready logic prevents overflow.
- app_rd_valid with rd_outstanding==0 and phase==0: beat dropped, phase unchanged, err_unexp_rd set (cleared only by reset).

phy_rdy behaviour:
- A phy_rdy drop does not abort an in-flight write beat 1 or clear outstanding reads.
- Returning read beats are collected in any state.

Test Plan:
- Reset, phy_rdy=0, request write → usr_req_ready=0, app_cmd_valid never 1; phy_rdy=1 → ready=1 in the second cycle after phy_rdy rises.
- Write addr=0x100, data={B1,B0}, be=36'hF_FFFF_FFFF → A+1: valid=1, rnw=0, addr=0x100, wr_data=B0, be=18'h3FFFF; A+2: valid=0, wr_data=B1; ready=0 at A+1.
- 9 consecutive read requests with MAX_RD_OUT=8 and no returns → 8 commands on 8 consecutive cycles, rd_outstanding=8, ready=0 for read; one 2-beat return (X then Y) → usr_rd_valid pulse with data {Y,X}, counter=7, 9th read issued.
- Read return second beat in the same cycle as a new read accept → rd_outstanding unchanged.
- app_rd_valid pulse after reset with nothing issued → err_unexp_rd=1, usr_rd_valid stays 0.
- Assert rst0_n low mid-write (in WR_B1) → all outputs 0 immediately; after release, phy_rdy=1 restores normal operation.

Source files
------------

// File: rtl/dram_req_sequencer.sv
// ============================================================================
// Module   : dram_req_sequencer
// Purpose  : Converts a 288-bit single-cycle user request port into the DDR2
//            controller's two-beat application protocol. Writes go out as a
//            command cycle carrying beat 0 followed by beat 1. Reads are
//            credit-limited, and their two return beats are reassembled into
//            one 288-bit response. All request traffic is gated on phy_rdy.
// Ports    : clk0, rst0_n            - clock, async active-low reset
//            phy_rdy                 - controller calibration complete
//            usr_req_* / usr_wr_*    - user request (valid/ready handshake)
//            usr_rd_valid/_data      - reassembled read response (1-cycle pulse)
//            rd_outstanding          - reads issued but not fully returned
//            err_unexp_rd            - sticky: read beat with nothing outstanding
//            app_cmd_* / app_wr_*    - registered controller command/write bus
//            app_rd_data/_valid      - controller read return beats
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dram_req_sequencer #(
  parameter int ADDR_WIDTH = 32,
  parameter int BEAT_WIDTH = 144,
  parameter int BE_WIDTH   = 18,
  parameter int MAX_RD_OUT = 8,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                    clk0,
  input  logic                    rst0_n,
  input  logic                    phy_rdy,
  input  logic                    usr_req_valid,
  output logic                    usr_req_ready,
  input  logic                    usr_req_rnw,
  input  logic [ADDR_WIDTH-1:0]   usr_req_addr,
  input  logic [2*BEAT_WIDTH-1:0] usr_wr_data,
  input  logic [2*BE_WIDTH-1:0]   usr_wr_be,
  output logic                    usr_rd_valid,
  output logic [2*BEAT_WIDTH-1:0] usr_rd_data,
  output logic [CNT_WIDTH-1:0]    rd_outstanding,
  output logic                    err_unexp_rd,
  output logic [ADDR_WIDTH-1:0]   app_cmd_addr,
  output logic                    app_cmd_rnw,
  output logic                    app_cmd_valid,
  output logic [BEAT_WIDTH-1:0]   app_wr_data,
  output logic [BE_WIDTH-1:0]     app_wr_be,
  input  logic [BEAT_WIDTH-1:0]   app_rd_data,
  input  logic                    app_rd_valid
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_WR_B1 = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    w_ready;
  logic                    w_accept;
  logic                    w_rd_inc;
  logic                    w_rd_dec;
  logic                    w_beat_lo;
  logic                    w_beat_unexp;
  logic                    w_full;

  logic                    r_phase;
  logic [BEAT_WIDTH-1:0]   r_rd_lo;
  logic [BEAT_WIDTH-1:0]   r_b1_data;
  logic [BE_WIDTH-1:0]     r_b1_be;
  logic [CNT_WIDTH-1:0]    r_rd_out;

  assign w_full   = (r_rd_out == CNT_WIDTH'(MAX_RD_OUT));
  assign w_accept = usr_req_valid && w_ready;
  assign w_rd_inc = w_accept && usr_req_rnw;

  // A beat in phase 0 with no read outstanding is a protocol error: drop it
  // without advancing the phase so a later legitimate pair stays aligned.
  assign w_beat_unexp = app_rd_valid && !r_phase && (r_rd_out == '0);
  assign w_beat_lo    = app_rd_valid && !r_phase && (r_rd_out != '0);
  assign w_rd_dec     = app_rd_valid && r_phase;

  assign usr_req_ready  = w_ready;
  assign rd_outstanding = r_rd_out;

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (phy_rdy) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        // Only reads are credit-limited; writes need nothing but phy_rdy.
        w_ready = phy_rdy && !(usr_req_rnw && w_full);
        if (w_accept && !usr_req_rnw) w_state_nxt = ST_WR_B1;
        else if (!w_accept && !phy_rdy) w_state_nxt = ST_IDLE;
      end
      ST_WR_B1: begin
        w_state_nxt = phy_rdy ? ST_RUN : ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Controller command / write-data bus. Address, rnw and write data hold
  // their last values while no command is issued.
  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      app_cmd_valid <= 1'b0;
      app_cmd_rnw   <= 1'b0;
      app_cmd_addr  <= '0;
      app_wr_data   <= '0;
      app_wr_be     <= '0;
      r_b1_data     <= '0;
      r_b1_be       <= '0;
    end else begin
      app_cmd_valid <= w_accept;
      if (w_accept) begin
        app_cmd_rnw  <= usr_req_rnw;
        app_cmd_addr <= usr_req_addr;
        if (!usr_req_rnw) begin
          app_wr_data <= usr_wr_data[BEAT_WIDTH-1:0];
          app_wr_be   <= usr_wr_be[BE_WIDTH-1:0];
          r_b1_data   <= usr_wr_data[2*BEAT_WIDTH-1:BEAT_WIDTH];
          r_b1_be     <= usr_wr_be[2*BE_WIDTH-1:BE_WIDTH];
        end
      end else if (r_state == ST_WR_B1) begin
        app_wr_data <= r_b1_data;
        app_wr_be   <= r_b1_be;
      end
    end
  end

  // Read return reassembly and outstanding-read credit counter.
  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      r_phase      <= 1'b0;
      r_rd_lo      <= '0;
      r_rd_out     <= '0;
      usr_rd_valid <= 1'b0;
      usr_rd_data  <= '0;
      err_unexp_rd <= 1'b0;
    end else begin
      usr_rd_valid <= w_rd_dec;
      if (w_beat_unexp) err_unexp_rd <= 1'b1;
      if (w_beat_lo) begin
        r_rd_lo <= app_rd_data;
        r_phase <= 1'b1;
      end
      if (w_rd_dec) begin
        usr_rd_data <= {app_rd_data, r_rd_lo};
        r_phase     <= 1'b0;
      end
      case ({w_rd_inc, w_rd_dec})
        2'b10:   r_rd_out <= r_rd_out + 1'b1;
        2'b01:   r_rd_out <= r_rd_out - 1'b1;
        default: r_rd_out <= r_rd_out;
      endcase
    end
  end

endmodule

`default_nettype wire
